// File: rtl/btn_debounce.sv
// Button/switch debouncer: 2-flop synchronizer + 4-state stability FSM with registered Q/Rise/Fall.
// Define DEBOUNCE_TOGGLE_EN to add the Toggle output (flips on every debounced press).
module btn_debounce #(
  parameter logic [24:0] STABLE_COUNT = 25'd500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Din,
  output logic Q,
  output logic Rise,
  output logic Fall
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic Toggle
`endif
);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] PEND_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] PEND_LOW    = 2'd3;

  localparam logic [24:0] CNT_LAST = STABLE_COUNT - 25'd1;

  logic [1:0]  sync;
  logic        Din_s;
  logic [1:0]  state, state_nx;
  logic [24:0] cnt, cnt_nx;
  logic        q_nx, rise_nx, fall_nx;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sync <= 2'b00;
    else       sync <= {sync[0], Din};
  end

  assign Din_s = sync[1];

  // >= rather than == so a corrupted count can never run past the threshold
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_nx     = Q;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (Din_s) begin
          state_nx = PEND_HIGH;
          cnt_nx   = 25'd1;
        end
      end
      PEND_HIGH: begin
        if (!Din_s) begin
          state_nx = STABLE_LOW;
          cnt_nx   = 25'd0;
        end else if (cnt >= CNT_LAST) begin
          state_nx = STABLE_HIGH;
          cnt_nx   = 25'd0;
          q_nx     = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 25'd1;
        end
      end
      STABLE_HIGH: begin
        if (!Din_s) begin
          state_nx = PEND_LOW;
          cnt_nx   = 25'd1;
        end
      end
      PEND_LOW: begin
        if (Din_s) begin
          state_nx = STABLE_HIGH;
          cnt_nx   = 25'd0;
        end else if (cnt >= CNT_LAST) begin
          state_nx = STABLE_LOW;
          cnt_nx   = 25'd0;
          q_nx     = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 25'd1;
        end
      end
      default: begin
        state_nx = STABLE_LOW;
        cnt_nx   = 25'd0;
        q_nx     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= STABLE_LOW;
      cnt   <= 25'd0;
      Q     <= 1'b0;
      Rise  <= 1'b0;
      Fall  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      Q     <= q_nx;
      Rise  <= rise_nx;
      Fall  <= fall_nx;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // flips on the same edge that raises Rise
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        Toggle <= 1'b0;
    else if (rise_nx) Toggle <= ~Toggle;
  end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (STABLE_COUNT=4): run-length reference model checked every cycle
// plus hand-computed edge counts and pulse tallies per scenario.
module tb_btn_debounce;
  localparam int SC = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Din = 1'b1;
  logic Q, Rise, Fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic Toggle;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  btn_debounce #(.STABLE_COUNT(25'd4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Din   (Din),
    .Q     (Q),
    .Rise  (Rise),
    .Fall  (Fall)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .Toggle(Toggle)
`endif
  );

  always #10 Clk = ~Clk;

  // Reference: Q flips once the synchronized input has disagreed with Q for SC consecutive edges.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_q = 1'b0, m_r = 1'b0, m_f = 1'b0, m_t = 1'b0;
  int   m_run = 0;

  always @(posedge Clk or posedge Reset) begin : mdl
    logic ds, nq, nr, nf, nt;
    int   nrun;
    if (Reset) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_q <= 1'b0; m_r <= 1'b0; m_f <= 1'b0; m_t <= 1'b0;
      m_run <= 0;
    end else begin
      ds   = m_s2;
      nq   = m_q;
      nr   = 1'b0;
      nf   = 1'b0;
      nt   = m_t;
      nrun = (ds != m_q) ? m_run + 1 : 0;
      if (nrun == SC) begin
        nq   = ~m_q;
        nrun = 0;
        if (nq) begin nr = 1'b1; nt = ~m_t; end
        else    nf = 1'b1;
      end
      m_s2 <= m_s1;
      m_s1 <= Din;
      m_q  <= nq;
      m_r  <= nr;
      m_f  <= nf;
      m_t  <= nt;
      m_run <= nrun;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    check("model_Q", int'(Q), int'(m_q));
    check("model_Rise", int'(Rise), int'(m_r));
    check("model_Fall", int'(Fall), int'(m_f));
    check("rise_fall_exclusive", int'(Rise & Fall), 0);
`ifdef DEBOUNCE_TOGGLE_EN
    check("model_Toggle", int'(Toggle), int'(m_t));
`endif
    if (Rise) rise_cnt++;
    if (Fall) fall_cnt++;
  end

  // Counts rising edges (first = 1) until the requested pulse is seen; 20 means it never came.
  task automatic edges_until(input bit want_rise, output int n);
    n = 0;
    while (n < 20) begin
      @(posedge Clk); #1;
      n++;
      if (want_rise ? Rise : Fall) break;
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge Clk);
  endtask

  initial begin
    int n, r0, f0;

    // reset with Din=1 held
    #5;
    check("rst_Q", int'(Q), 0);
    check("rst_Rise", int'(Rise), 0);
    check("rst_Fall", int'(Fall), 0);
`ifdef DEBOUNCE_TOGGLE_EN
    check("rst_Toggle", int'(Toggle), 0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    edges_until(1'b1, n);
    check("rst_rise_edge", n, 6);
    check("rst_rise_Q", int'(Q), 1);
    @(posedge Clk); #1;
    check("rst_rise_one_cycle", int'(Rise), 0);

    // release
    @(negedge Clk);
    Din = 1'b0;
    edges_until(1'b0, n);
    check("release_fall_edge", n, 6);
    check("release_Q", int'(Q), 0);
    cycles(4);

    // clean press, 10 cycles
    r0 = rise_cnt; f0 = fall_cnt;
    Din = 1'b1;
    edges_until(1'b1, n);
    check("press_rise_edge", n, 6);
    cycles(4);
    check("press_rise_count", rise_cnt - r0, 1);
    check("press_no_fall", fall_cnt - f0, 0);
    Din = 1'b0;
    cycles(12);

    // bounce: 1,0,1,0 each 2 cycles, then hold 1
    r0 = rise_cnt; f0 = fall_cnt;
    Din = 1'b1; cycles(2);
    Din = 1'b0; cycles(2);
    Din = 1'b1; cycles(2);
    Din = 1'b0; cycles(2);
    check("bounce_Q_low", int'(Q), 0);
    Din = 1'b1;
    edges_until(1'b1, n);
    check("bounce_rise_edge", n, 6);
    cycles(6);
    check("bounce_single_rise", rise_cnt - r0, 1);
    check("bounce_no_fall", fall_cnt - f0, 0);
    Din = 1'b0;
    cycles(12);

    // glitch: 3 sampled cycles high
    r0 = rise_cnt; f0 = fall_cnt;
    Din = 1'b1; cycles(3);
    Din = 1'b0; cycles(12);
    check("glitch_Q", int'(Q), 0);
    check("glitch_no_rise", rise_cnt - r0, 0);
    check("glitch_no_fall", fall_cnt - f0, 0);

    // press, release, press
    r0 = rise_cnt; f0 = fall_cnt;
    Din = 1'b1; cycles(10);
    check("seq_after_press1", rise_cnt - r0, 1);
    Din = 1'b0; cycles(10);
    check("seq_after_release", fall_cnt - f0, 1);
    Din = 1'b1; cycles(10);
    check("seq_after_press2", rise_cnt - r0, 2);
    check("seq_Q", int'(Q), 1);
`ifdef DEBOUNCE_TOGGLE_EN
    check("seq_Toggle", int'(Toggle), 1);
`endif
    Din = 1'b0;
    cycles(12);

    // reset mid-count at the 4th sampling edge
    r0 = rise_cnt; f0 = fall_cnt;
    Din = 1'b1;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("midrst_Q", int'(Q), 0);
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_no_rise", rise_cnt - r0, 0);
    edges_until(1'b1, n);
    check("midrst_restart_edge", n, 6);
    check("midrst_no_fall", fall_cnt - f0, 0);
    cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
